// File: rtl/dsfq_and_gate.sv
// Cycle-based model of a dynamic SFQ AND gate with toggle-encoded I/O.
// Each input pulse is held for WINDOW cycles; a coincidence of both inputs
// emits one output toggle OUT_DELAY cycles later.
module dsfq_and_gate #(
    parameter int unsigned WINDOW    = 4,
    parameter int unsigned OUT_DELAY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic q,
    output logic q_pulse,
    output logic err
);

    localparam int unsigned CW = $clog2(WINDOW + 1);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_ARMED = 1'b1;

    logic                 a_prev_q, b_prev_q;
    logic                 st_a_q, st_a_d;
    logic                 st_b_q, st_b_d;
    logic [CW-1:0]        cnt_a_q, cnt_a_d;
    logic [CW-1:0]        cnt_b_q, cnt_b_d;
    logic [OUT_DELAY-1:0] pipe_q, pipe_d;
    logic                 q_q;

    logic pa, pb;
    logic arm_a, arm_b;
    logic fire;
    logic dup_a, dup_b;

    // Pulse detection, coincidence and duplicate-pulse classification
    always_comb begin
        pa    = a ^ a_prev_q;
        pb    = b ^ b_prev_q;
        arm_a = (st_a_q == ST_ARMED);
        arm_b = (st_b_q == ST_ARMED);
        fire  = (pa | arm_a) & (pb | arm_b) & (pa | pb);
        dup_a = pa & arm_a & ~fire;
        dup_b = pb & arm_b & ~fire;
    end

    // Per-input storage: arm/reload on a pulse, decay one step per idle cycle
    always_comb begin
        st_a_d  = st_a_q;
        cnt_a_d = cnt_a_q;
        st_b_d  = st_b_q;
        cnt_b_d = cnt_b_q;
        if (fire) begin
            st_a_d  = ST_IDLE;
            cnt_a_d = '0;
            st_b_d  = ST_IDLE;
            cnt_b_d = '0;
        end else begin
            if (pa) begin
                st_a_d  = ST_ARMED;
                cnt_a_d = CW'(WINDOW);
            end else if (arm_a) begin
                cnt_a_d = cnt_a_q - CW'(1);
                if (cnt_a_q == CW'(1)) begin
                    st_a_d = ST_IDLE;
                end
            end
            if (pb) begin
                st_b_d  = ST_ARMED;
                cnt_b_d = CW'(WINDOW);
            end else if (arm_b) begin
                cnt_b_d = cnt_b_q - CW'(1);
                if (cnt_b_q == CW'(1)) begin
                    st_b_d = ST_IDLE;
                end
            end
        end
    end

    // Output delay line: stage 0 captures the fire, last stage is the strobe
    always_comb begin
        pipe_d[0] = fire;
        for (int unsigned i = 1; i < OUT_DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // State registers; q toggles on the same edge the event reaches the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_prev_q <= 1'b0;
            b_prev_q <= 1'b0;
            st_a_q   <= ST_IDLE;
            st_b_q   <= ST_IDLE;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            pipe_q   <= '0;
            q_q      <= 1'b0;
        end else begin
            a_prev_q <= a;
            b_prev_q <= b;
            st_a_q   <= st_a_d;
            st_b_q   <= st_b_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            pipe_q   <= pipe_d;
            q_q      <= q_q ^ pipe_d[OUT_DELAY-1];
        end
    end

    assign q       = q_q;
    assign q_pulse = pipe_q[OUT_DELAY-1];
    assign err     = dup_a | dup_b;

endmodule

// File: tb/tb_dsfq_and_gate.sv
// Self-checking bench for dsfq_and_gate: directed scenarios plus random
// toggles, compared every cycle against a time-stamp based reference model.
module tb_dsfq_and_gate;

    localparam int W = 4;
    localparam int D = 2;
    localparam int NONE = -1000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;
    logic q, q_pulse, err;

    int tests = 0;
    int fails = 0;

    dsfq_and_gate #(.WINDOW(W), .OUT_DELAY(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .q      (q),
        .q_pulse(q_pulse),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Reference model: arrival time of each stored pulse, queue of due times
    int   mcyc = 0;
    int   ta = NONE;
    int   tb = NONE;
    logic ap = 1'b0;
    logic bp = 1'b0;
    logic qm = 1'b0;
    int   due[$];

    logic q_log[64];
    logic qp_log[64];
    logic err_log[64];
    int   lidx = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ta = NONE;
        tb = NONE;
        ap = 1'b0;
        bp = 1'b0;
        qm = 1'b0;
        due.delete();
    endtask

    // Evaluate the model for the current cycle and compare all outputs
    task automatic eval_and_check();
        logic pa, pb, va, vb, fire, e_err, e_qp;
        pa    = (a != ap);
        pb    = (b != bp);
        va    = (mcyc - ta) <= W;
        vb    = (mcyc - tb) <= W;
        fire  = (pa || va) && (pb || vb) && (pa || pb);
        e_err = !fire && ((pa && va) || (pb && vb));
        e_qp  = 1'b0;
        if (due.size() > 0 && due[0] == mcyc) begin
            void'(due.pop_front());
            e_qp = 1'b1;
            qm   = ~qm;
        end
        chk("q", int'(q), int'(qm));
        chk("q_pulse", int'(q_pulse), int'(e_qp));
        chk("err", int'(err), int'(e_err));
        if (fire) begin
            ta = NONE;
            tb = NONE;
            due.push_back(mcyc + D);
        end else begin
            if (pa) ta = mcyc;
            if (pb) tb = mcyc;
        end
        ap = a;
        bp = b;
        mcyc++;
    endtask

    task automatic step(input logic na, input logic nb);
        a = na;
        b = nb;
        @(negedge clk);
        eval_and_check();
        if (lidx < 64) begin
            q_log[lidx]   = q;
            qp_log[lidx]  = q_pulse;
            err_log[lidx] = err;
        end
        lidx++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a   = 1'b0;
        b   = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_q", int'(q), 0);
        chk("rst_q_pulse", int'(q_pulse), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Toggle a at cycles ac0/ac1 and b at bc0/bc1 (-1 = unused), len cycles
    task automatic run(input int ac0, input int ac1, input int bc0, input int bc1, input int len);
        logic na, nb;
        na   = a;
        nb   = b;
        lidx = 0;
        for (int k = 0; k < len; k++) begin
            if (k == ac0 || k == ac1) na = ~na;
            if (k == bc0 || k == bc1) nb = ~nb;
            step(na, nb);
        end
    endtask

    function automatic int err_count(input int len);
        int n = 0;
        for (int k = 0; k < len; k++) n += int'(err_log[k]);
        return n;
    endfunction

    initial begin
        // Basic coincidence: a at 2, b at 3 -> toggle at 5
        do_reset();
        run(2, -1, 3, -1, 8);
        chk("t1_q4", int'(q_log[4]), 0);
        chk("t1_q5", int'(q_log[5]), 1);
        chk("t1_qp4", int'(qp_log[4]), 0);
        chk("t1_qp5", int'(qp_log[5]), 1);
        chk("t1_q7", int'(q_log[7]), 1);
        chk("t1_err", err_count(8), 0);

        // Decay: a at 0, b at 10 -> no output
        do_reset();
        run(0, -1, 10, -1, 20);
        chk("t2_q19", int'(q_log[19]), 0);
        chk("t2_err", err_count(20), 0);

        // Window boundary
        do_reset();
        run(0, -1, 4, -1, 10);
        chk("t3a_q5", int'(q_log[5]), 0);
        chk("t3a_q6", int'(q_log[6]), 1);
        do_reset();
        run(0, -1, 5, -1, 10);
        chk("t3b_q9", int'(q_log[9]), 0);

        // Simultaneous pulses at 1, lone b at 4
        do_reset();
        run(1, -1, 1, 4, 12);
        chk("t4_q2", int'(q_log[2]), 0);
        chk("t4_q3", int'(q_log[3]), 1);
        chk("t4_q11", int'(q_log[11]), 1);
        chk("t4_err", err_count(12), 0);

        // Duplicate reloads the window
        do_reset();
        run(0, 3, 7, -1, 12);
        chk("t5_err3", int'(err_log[3]), 1);
        chk("t5_errn", err_count(12), 1);
        chk("t5_q8", int'(q_log[8]), 0);
        chk("t5_q9", int'(q_log[9]), 1);

        // Reset mid-operation discards the pending output
        do_reset();
        run(0, -1, 1, -1, 2);
        do_reset();
        run(-1, -1, 0, -1, 10);
        chk("t6_q", int'(q_log[9]), 0);
        chk("t6_qp3", int'(qp_log[3]), 0);

        // Random toggles with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic na, nb;
            if ($urandom_range(0, 299) == 0) do_reset();
            na = a;
            nb = b;
            if ($urandom_range(0, 3) == 0) na = ~na;
            if ($urandom_range(0, 4) == 0) nb = ~nb;
            step(na, nb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
